// File: rtl/time_keeper.sv
// time_keeper: divides CP50 down to a 1 Hz tick, keeps HH:MM:SS in BCD, lets the
// user set hours and minutes with two buttons, and drives registered active-low
// 7-segment patterns (HEX3..HEX0 = H tens, H ones, M tens, M ones).
module time_keeper #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic       CP50,
   input  logic       CR,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic       sec_led,
   output logic [1:0] mode
);

   localparam int               CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2);
   localparam logic [6:0]       SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2
   } state_e;

   state_e           state_q;
   logic [1:0]       mode_q;
   logic             mode_s1_q, mode_s2_q, mode_hist_q;
   logic             inc_s1_q, inc_s2_q, inc_hist_q;
   logic             mode_pulse, inc_pulse;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick, first_half;
   logic [3:0]       sec_t_q, sec_t_d, sec_o_q, sec_o_d;
   logic [3:0]       min_t_q, min_t_d, min_o_q, min_o_d;
   logic [1:0]       hr_t_q, hr_t_d;
   logic [3:0]       hr_o_q, hr_o_d;
   logic [3:0]       sec_t_inc, sec_o_inc, min_t_inc, min_o_inc, hr_o_inc;
   logic [1:0]       hr_t_inc;
   logic             sec_wrap, min_wrap, hr_wrap;
   logic             blank_hr, blank_min;
   logic [6:0]       hex0_q, hex1_q, hex2_q, hex3_q;
   logic             sec_led_q;

   function automatic logic [6:0] seg7(input logic [3:0] digit);
      logic [6:0] pat;
      case (digit)
         4'd0:    pat = 7'b1000000;
         4'd1:    pat = 7'b1111001;
         4'd2:    pat = 7'b0100100;
         4'd3:    pat = 7'b0110000;
         4'd4:    pat = 7'b0011001;
         4'd5:    pat = 7'b0010010;
         4'd6:    pat = 7'b0000010;
         4'd7:    pat = 7'b1111000;
         4'd8:    pat = 7'b0000000;
         4'd9:    pat = 7'b0010000;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

   // Two synchronizer flops and one history flop per button for rising-edge detect.
   always_ff @(posedge CP50) begin
      if (CR) begin
         mode_s1_q   <= 1'b0;
         mode_s2_q   <= 1'b0;
         mode_hist_q <= 1'b0;
         inc_s1_q    <= 1'b0;
         inc_s2_q    <= 1'b0;
         inc_hist_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so each stage captures the previous stage's old value.
         mode_s1_q   <= mode_btn;
         mode_s2_q   <= mode_s1_q;
         mode_hist_q <= mode_s2_q;
         inc_s1_q    <= inc_btn;
         inc_s2_q    <= inc_s1_q;
         inc_hist_q  <= inc_s2_q;
      end
   end

   assign mode_pulse = mode_s2_q & ~mode_hist_q;
   assign inc_pulse  = inc_s2_q & ~inc_hist_q;

   assign tick       = (cnt_q == CNT_LAST);
   assign first_half = (cnt_q < CNT_HALF);

   // BCD increment candidates for each field.
   assign sec_wrap  = (sec_t_q == 4'd5) && (sec_o_q == 4'd9);
   assign min_wrap  = (min_t_q == 4'd5) && (min_o_q == 4'd9);
   assign hr_wrap   = (hr_t_q == 2'd2) && (hr_o_q == 4'd3);
   assign sec_o_inc = (sec_o_q == 4'd9) ? 4'd0 : sec_o_q + 4'd1;
   assign sec_t_inc = (sec_o_q != 4'd9) ? sec_t_q : (sec_t_q == 4'd5) ? 4'd0 : sec_t_q + 4'd1;
   assign min_o_inc = (min_o_q == 4'd9) ? 4'd0 : min_o_q + 4'd1;
   assign min_t_inc = (min_o_q != 4'd9) ? min_t_q : (min_t_q == 4'd5) ? 4'd0 : min_t_q + 4'd1;
   assign hr_o_inc  = (hr_wrap || hr_o_q == 4'd9) ? 4'd0 : hr_o_q + 4'd1;
   assign hr_t_inc  = hr_wrap ? 2'd0 : (hr_o_q == 4'd9) ? hr_t_q + 2'd1 : hr_t_q;

   // Mode FSM: each mode pulse steps RUN -> SET_HOUR -> SET_MIN -> RUN; mode is a registered copy.
   always_ff @(posedge CP50) begin
      if (CR) begin
         state_q <= ST_RUN;
         mode_q  <= 2'd0;
      end else begin
         mode_q <= state_q;
         if (mode_pulse) begin
            case (state_q)
               ST_RUN:      state_q <= ST_SET_HOUR;
               ST_SET_HOUR: state_q <= ST_SET_MIN;
               default:     state_q <= ST_RUN;
            endcase
         end
      end
   end

   // Next prescaler and time values; a mode pulse in the same cycle drops any inc.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      sec_t_d = sec_t_q;
      sec_o_d = sec_o_q;
      min_t_d = min_t_q;
      min_o_d = min_o_q;
      hr_t_d  = hr_t_q;
      hr_o_d  = hr_o_q;
      case (state_q)
         ST_RUN: begin
            if (tick) begin
               sec_t_d = sec_t_inc;
               sec_o_d = sec_o_inc;
               if (sec_wrap) begin
                  min_t_d = min_t_inc;
                  min_o_d = min_o_inc;
                  if (min_wrap) begin
                     hr_t_d = hr_t_inc;
                     hr_o_d = hr_o_inc;
                  end
               end
            end
         end
         ST_SET_HOUR: begin
            if (inc_pulse && !mode_pulse) begin
               hr_t_d = hr_t_inc;
               hr_o_d = hr_o_inc;
            end
         end
         default: begin
            if (mode_pulse) begin
               // Leaving set mode restarts the second from its beginning.
               sec_t_d = 4'd0;
               sec_o_d = 4'd0;
               cnt_d   = '0;
            end else if (inc_pulse) begin
               min_t_d = min_t_inc;
               min_o_d = min_o_inc;
            end
         end
      endcase
   end

   // Prescaler and time-of-day registers.
   always_ff @(posedge CP50) begin
      if (CR) begin
         cnt_q   <= '0;
         sec_t_q <= 4'd0;
         sec_o_q <= 4'd0;
         min_t_q <= 4'd0;
         min_o_q <= 4'd0;
         hr_t_q  <= 2'd0;
         hr_o_q  <= 4'd0;
      end else begin
         cnt_q   <= cnt_d;
         sec_t_q <= sec_t_d;
         sec_o_q <= sec_o_d;
         min_t_q <= min_t_d;
         min_o_q <= min_o_d;
         hr_t_q  <= hr_t_d;
         hr_o_q  <= hr_o_d;
      end
   end

   assign blank_hr  = (state_q == ST_SET_HOUR) && !first_half;
   assign blank_min = (state_q == ST_SET_MIN) && !first_half;

   // Registered segment patterns with blinking of the field being set, plus the second LED.
   always_ff @(posedge CP50) begin
      if (CR) begin
         hex0_q    <= seg7(4'd0);
         hex1_q    <= seg7(4'd0);
         hex2_q    <= seg7(4'd0);
         hex3_q    <= seg7(4'd0);
         sec_led_q <= 1'b0;
      end else begin
         hex0_q    <= blank_min ? SEG_BLANK : seg7(min_o_q);
         hex1_q    <= blank_min ? SEG_BLANK : seg7(min_t_q);
         hex2_q    <= blank_hr  ? SEG_BLANK : seg7(hr_o_q);
         hex3_q    <= blank_hr  ? SEG_BLANK : seg7({2'b00, hr_t_q});
         sec_led_q <= first_half;
      end
   end

   assign HEX0    = hex0_q;
   assign HEX1    = hex1_q;
   assign HEX2    = hex2_q;
   assign HEX3    = hex3_q;
   assign sec_led = sec_led_q;
   assign mode    = mode_q;

endmodule

// File: tb/tb_time_keeper.sv
// Testbench for time_keeper: directed vector table, hand-written set/rollover
// sequences, and randomized buttons/reset checked every cycle against a
// behavioural clock model.
module tb_time_keeper;

   localparam int         TD    = 4;
   localparam logic [6:0] BLANK = 7'b1111111;

   logic       CP50     = 1'b0;
   logic       CR       = 1'b1;
   logic       mode_btn = 1'b0;
   logic       inc_btn  = 1'b0;
   logic [6:0] HEX0, HEX1, HEX2, HEX3;
   logic       sec_led;
   logic [1:0] mode;

   time_keeper #(.TICK_DIV(TD)) dut (
      .CP50    (CP50),
      .CR      (CR),
      .mode_btn(mode_btn),
      .inc_btn (inc_btn),
      .HEX0    (HEX0),
      .HEX1    (HEX1),
      .HEX2    (HEX2),
      .HEX3    (HEX3),
      .sec_led (sec_led),
      .mode    (mode)
   );

   always #5 CP50 = ~CP50;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Segment patterns for digits 0..9, active-low gfedcba.
   logic [6:0] seg_lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // ---------------- behavioural reference model ----------------
   int         m_h = 0, m_m = 0, m_s = 0, m_cnt = 0, m_mode = 0;
   bit         mb_hist [3];
   bit         ib_hist [3];
   logic [6:0] e_hex [4] = '{7'h40, 7'h40, 7'h40, 7'h40};
   logic       e_led  = 1'b0;
   logic [1:0] e_mode = 2'd0;

   always @(posedge CP50) begin : model
      bit fh, mp, ip, tk;
      int nxt_cnt;
      if (CR) begin
         m_h = 0; m_m = 0; m_s = 0; m_cnt = 0; m_mode = 0;
         for (int i = 0; i < 3; i++) begin
            mb_hist[i] = 1'b0;
            ib_hist[i] = 1'b0;
         end
         for (int i = 0; i < 4; i++) e_hex[i] = seg_lut[0];
         e_led  = 1'b0;
         e_mode = 2'd0;
      end else begin
         fh       = (m_cnt < TD / 2);
         e_led    = fh;
         e_mode   = 2'(m_mode);
         e_hex[3] = (m_mode == 1 && !fh) ? BLANK : seg_lut[m_h / 10];
         e_hex[2] = (m_mode == 1 && !fh) ? BLANK : seg_lut[m_h % 10];
         e_hex[1] = (m_mode == 2 && !fh) ? BLANK : seg_lut[m_m / 10];
         e_hex[0] = (m_mode == 2 && !fh) ? BLANK : seg_lut[m_m % 10];
         mp       = mb_hist[1] && !mb_hist[2];
         ip       = ib_hist[1] && !ib_hist[2];
         tk       = (m_cnt == TD - 1);
         nxt_cnt  = (m_cnt + 1) % TD;
         case (m_mode)
            0: begin
               if (tk) begin
                  m_s++;
                  if (m_s == 60) begin
                     m_s = 0;
                     m_m++;
                     if (m_m == 60) begin
                        m_m = 0;
                        m_h = (m_h + 1) % 24;
                     end
                  end
               end
               if (mp) m_mode = 1;
            end
            1: begin
               if (mp) m_mode = 2;
               else if (ip) m_h = (m_h + 1) % 24;
            end
            default: begin
               if (mp) begin
                  m_mode  = 0;
                  m_s     = 0;
                  nxt_cnt = 0;
               end else if (ip) begin
                  m_m = (m_m + 1) % 60;
               end
            end
         endcase
         m_cnt      = nxt_cnt;
         mb_hist[2] = mb_hist[1];
         mb_hist[1] = mb_hist[0];
         mb_hist[0] = mode_btn;
         ib_hist[2] = ib_hist[1];
         ib_hist[1] = ib_hist[0];
         ib_hist[0] = inc_btn;
      end
   end

   // Every cycle, compare all outputs against the model, away from the active edge.
   always @(negedge CP50) begin
      check("model_hex0", 32'(HEX0), 32'(e_hex[0]));
      check("model_hex1", 32'(HEX1), 32'(e_hex[1]));
      check("model_hex2", 32'(HEX2), 32'(e_hex[2]));
      check("model_hex3", 32'(HEX3), 32'(e_hex[3]));
      check("model_sec_led", 32'(sec_led), 32'(e_led));
      check("model_mode", 32'(mode), 32'(e_mode));
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(negedge CP50);
   endtask

   task automatic press_mode();
      mode_btn = 1'b1;
      step(4);
      mode_btn = 1'b0;
      step(4);
   endtask

   task automatic press_inc();
      inc_btn = 1'b1;
      step(4);
      inc_btn = 1'b0;
      step(4);
   endtask

   // Advance (bounded) to a cycle where the display is not in its blank phase.
   task automatic wait_lit(input string name);
      bit found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
         if (e_led) found = 1'b1;
         else step(1);
      end
      check(name, 32'(found), 32'd1);
   endtask

   typedef struct {
      logic       cr;
      logic       mb;
      logic       ib;
      logic [6:0] hex0;
      logic       led;
      logic [1:0] mode;
   } vec_t;

   vec_t tbl [10];

   initial begin : main
      int lit;
      int n;
      bit seen_24;

      // Reset held two cycles, then the first two seconds of sec_led square wave.
      tbl[0] = '{1'b1, 1'b0, 1'b0, 7'h40, 1'b0, 2'd0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 7'h40, 1'b0, 2'd0};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 7'h40, 1'b1, 2'd0};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 7'h40, 1'b1, 2'd0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 7'h40, 1'b0, 2'd0};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 7'h40, 1'b0, 2'd0};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 7'h40, 1'b1, 2'd0};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 7'h40, 1'b1, 2'd0};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 7'h40, 1'b0, 2'd0};
      tbl[9] = '{1'b0, 1'b0, 1'b0, 7'h40, 1'b0, 2'd0};
      for (int i = 0; i < 10; i++) begin
         CR       = tbl[i].cr;
         mode_btn = tbl[i].mb;
         inc_btn  = tbl[i].ib;
         step(1);
         check($sformatf("vec%0d_hex0", i), 32'(HEX0), 32'(tbl[i].hex0));
         check($sformatf("vec%0d_sec_led", i), 32'(sec_led), 32'(tbl[i].led));
         check($sformatf("vec%0d_mode", i), 32'(mode), 32'(tbl[i].mode));
      end

      // First minute rollover: HEX0 turns '1' exactly 60*TD+1 edges after release.
      step(232);
      check("pre_rollover_hex0", 32'(HEX0), 32'h40);
      step(1);
      check("rollover_hex0", 32'(HEX0), 32'h79);
      step(1);
      check("rollover_hex0_hold", 32'(HEX0), 32'h79);
      check("rollover_hex1", 32'(HEX1), 32'h40);
      check("rollover_hex2", 32'(HEX2), 32'h40);
      check("rollover_hex3", 32'(HEX3), 32'h40);

      // Set 23:59, return to RUN, and watch the day wrap to 00:00.
      press_mode();
      check("set_hour_mode", 32'(mode), 32'd1);
      n = (23 - m_h + 24) % 24;
      repeat (n) press_inc();
      press_mode();
      check("set_min_mode", 32'(mode), 32'd2);
      n = (59 - m_m + 60) % 60;
      repeat (n) press_inc();
      // Press back to RUN: seconds restart at edge k+2, wrap shows at edge k+243.
      mode_btn = 1'b1;
      step(4);
      mode_btn = 1'b0;
      step(4);
      check("back_to_run_mode", 32'(mode), 32'd0);
      seen_24 = 1'b0;
      for (int i = 0; i < 235; i++) begin
         step(1);
         if (HEX3 == 7'h24 && HEX2 == 7'h19) seen_24 = 1'b1;
      end
      check("pre_wrap_hex3", 32'(HEX3), 32'h24);
      check("pre_wrap_hex2", 32'(HEX2), 32'h30);
      check("pre_wrap_hex1", 32'(HEX1), 32'h12);
      check("pre_wrap_hex0", 32'(HEX0), 32'h10);
      step(1);
      if (HEX3 == 7'h24 && HEX2 == 7'h19) seen_24 = 1'b1;
      check("wrap_hex3", 32'(HEX3), 32'h40);
      check("wrap_hex2", 32'(HEX2), 32'h40);
      check("wrap_hex1", 32'(HEX1), 32'h40);
      check("wrap_hex0", 32'(HEX0), 32'h40);
      check("no_24_transient", 32'(seen_24), 32'd0);

      // SET_HOUR blink: hours 05 alternate with blank, minutes stay steady.
      press_mode();
      repeat (5) press_inc();
      check("blink_mode", 32'(mode), 32'd1);
      lit = 0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         if (e_led) begin
            lit++;
            check("blink_hr_tens_lit", 32'(HEX3), 32'h40);
            check("blink_hr_ones_lit", 32'(HEX2), 32'h12);
         end else begin
            check("blink_hr_tens_blank", 32'(HEX3), 32'(BLANK));
            check("blink_hr_ones_blank", 32'(HEX2), 32'(BLANK));
         end
         check("blink_min_tens_steady", 32'(HEX1), 32'h40);
         check("blink_min_ones_steady", 32'(HEX0), 32'h40);
      end
      check("blink_lit_cycles", 32'(lit), 32'd2);

      // Mode and inc rising together in RUN: mode wins, hours unchanged.
      press_mode();
      press_mode();
      check("run_again_mode", 32'(mode), 32'd0);
      mode_btn = 1'b1;
      inc_btn  = 1'b1;
      step(4);
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
      step(4);
      wait_lit("simul_lit_found");
      check("simul_mode", 32'(mode), 32'd1);
      check("simul_hr_ones", 32'(HEX2), 32'h12);
      check("simul_hr_tens", 32'(HEX3), 32'h40);

      // A long-held inc gives a single increment: 05 -> 06.
      inc_btn = 1'b1;
      step(20);
      inc_btn = 1'b0;
      step(4);
      wait_lit("held_lit_found");
      check("held_inc_hr_ones", 32'(HEX2), 32'h02);
      check("held_inc_hr_tens", 32'(HEX3), 32'h40);

      // Reach 05:37 in SET_MIN, then a one-cycle CR.
      n = (5 - m_h + 24) % 24;
      repeat (n) press_inc();
      press_mode();
      n = (37 - m_m + 60) % 60;
      repeat (n) press_inc();
      wait_lit("set_min_lit_found");
      check("set_min_0537_mode", 32'(mode), 32'd2);
      check("set_min_0537_hex1", 32'(HEX1), 32'h30);
      check("set_min_0537_hex0", 32'(HEX0), 32'h78);
      check("set_min_0537_hex2", 32'(HEX2), 32'h12);
      CR = 1'b1;
      step(1);
      CR = 1'b0;
      check("cr_mid_set_hex3", 32'(HEX3), 32'h40);
      check("cr_mid_set_hex2", 32'(HEX2), 32'h40);
      check("cr_mid_set_hex1", 32'(HEX1), 32'h40);
      check("cr_mid_set_hex0", 32'(HEX0), 32'h40);
      check("cr_mid_set_mode", 32'(mode), 32'd0);
      check("cr_mid_set_sec_led", 32'(sec_led), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(1);
         check("after_cr_no_blank_hex0", 32'(HEX0), 32'h40);
         check("after_cr_no_blank_hex3", 32'(HEX3), 32'h40);
      end

      // Randomized buttons and occasional reset, checked by the per-cycle model compare.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(15) == 0) mode_btn = ~mode_btn;
         if ($urandom_range(3) == 0)  inc_btn  = ~inc_btn;
         CR = ($urandom_range(399) == 0);
         step(1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
